alu_share_arb: RTL

- Shares one 32-bit ALU instance between two requesters, e.g. the main execute stage (port 0) and a multi-cycle helper such as a branch/address unit (port 1).
- Each port uses a valid/ready request handshake and a valid/ready response handshake.
- Round-robin arbitration with a 2-stage issue/capture pipeline, sustaining 1 op/cycle.
- The block drives the ALU's aluc/a/b inputs from registers and captures r plus the four flags.

---
 rtl/alu_share_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Two-port round-robin front end for one shared ALU: accept -> issue register -> capture into a per-port response slot.
// Optional `ALU_ARB_PERF_EN adds saturating grant/conflict counters (perf_grant0, perf_grant1, perf_conflict).
module alu_share_arb #(
    parameter int DATA_W    = 32,
    parameter int ALUC_W    = 4,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ALUC_W-1:0] req0_aluc,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ALUC_W-1:0] req1_aluc,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_r,
    output logic [3:0]        rsp0_flags,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_r,
    output logic [3:0]        rsp1_flags,

    output logic [ALUC_W-1:0] alu_aluc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_negative,
    input  logic              alu_overflow
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]       perf_grant0,
    output logic [15:0]       perf_grant1,
    output logic [15:0]       perf_conflict
`endif
);

    logic              r_iss_valid;
    logic              r_iss_tag;
    logic              r_prio;
    logic [ALUC_W-1:0] r_alu_aluc;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;

    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_r     [2];
    logic [3:0]        r_rsp_flags [2];

    logic [1:0]        w_rsp_ready;
    logic [1:0]        w_free;
    logic [1:0]        w_elig;
    logic [1:0]        w_grant;
    logic              w_any_grant;
    logic [ALUC_W-1:0] w_sel_aluc;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [3:0]        w_alu_flags;

    assign w_rsp_ready = {rsp1_ready, rsp0_ready};
    assign w_alu_flags = {alu_zero, alu_carry, alu_negative, alu_overflow};

    // An op sitting in the issue register lands in its slot this edge, so its
    // port must wait one cycle; that keeps captures out of occupied slots.
    always_comb begin
        w_free     = ~r_rsp_valid | w_rsp_ready;
        w_elig[0]  = req0_valid & w_free[0] & ~(r_iss_valid & ~r_iss_tag);
        w_elig[1]  = req1_valid & w_free[1] & ~(r_iss_valid &  r_iss_tag);
        w_grant[0] = ~rst & w_elig[0] & (~w_elig[1] | ~r_prio);
        w_grant[1] = ~rst & w_elig[1] & (~w_elig[0] |  r_prio);
        w_any_grant = |w_grant;
        w_sel_aluc = req0_aluc;
        w_sel_a    = req0_a;
        w_sel_b    = req0_b;
        if (w_grant[1]) begin
            w_sel_aluc = req1_aluc;
            w_sel_a    = req1_a;
            w_sel_b    = req1_b;
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // Issue stage; operand registers hold their value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_tag   <= 1'b0;
            r_prio      <= INIT_PRIO;
            r_alu_aluc  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
        end else if (w_any_grant) begin
            r_iss_valid <= 1'b1;
            r_iss_tag   <= w_grant[1];
            r_prio      <= ~w_grant[1];
            r_alu_aluc  <= w_sel_aluc;
            r_alu_a     <= w_sel_a;
            r_alu_b     <= w_sel_b;
        end else begin
            r_iss_valid <= 1'b0;
        end
    end

    assign alu_aluc = r_alu_aluc;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;

    // Capture stage; a capture overrides a same-cycle drain of that slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            for (int n = 0; n < 2; n++) begin
                r_rsp_r[n]     <= '0;
                r_rsp_flags[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (r_iss_valid && (r_iss_tag == 1'(n))) begin
                    r_rsp_valid[n] <= 1'b1;
                    r_rsp_r[n]     <= alu_r;
                    r_rsp_flags[n] <= w_alu_flags;
                end else if (r_rsp_valid[n] && w_rsp_ready[n]) begin
                    r_rsp_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign rsp0_valid = r_rsp_valid[0];
    assign rsp0_r     = r_rsp_r[0];
    assign rsp0_flags = r_rsp_flags[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp1_r     = r_rsp_r[1];
    assign rsp1_flags = r_rsp_flags[1];

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_perf_g0;
    logic [15:0] r_perf_g1;
    logic [15:0] r_perf_conf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_g0   <= '0;
            r_perf_g1   <= '0;
            r_perf_conf <= '0;
        end else begin
            if (w_grant[0] && (r_perf_g0 != 16'hFFFF))
                r_perf_g0 <= r_perf_g0 + 16'd1;
            if (w_grant[1] && (r_perf_g1 != 16'hFFFF))
                r_perf_g1 <= r_perf_g1 + 16'd1;
            if ((&w_elig) && (r_perf_conf != 16'hFFFF))
                r_perf_conf <= r_perf_conf + 16'd1;
        end
    end

    assign perf_grant0   = r_perf_g0;
    assign perf_grant1   = r_perf_g1;
    assign perf_conflict = r_perf_conf;
`endif

endmodule
